chimera_reg_to_apb: RTL
=======================

Name: chimera_reg_to_apb

Overview:
- Bridge from the SoC register-interface bus to an APB4 target.
- Sits directly downstream of the external register-bus demux and upstream of the Pad (0x3000_2000–0x3000_3000) and FLL (0x3000_3000–0x3000_4000) configuration peripherals.
- Converts one valid/ready register transaction into one APB SETUP/ACCESS transfer and returns read data and an error flag.
- Adds a programmable PREADY timeout so a hung peripheral cannot lock the register bus.

Parameters:
- AddrWidth, 32, address width of both buses.
- DataWidth, 32, data width of both buses; must be 32 to match the package APB types.
- TimeoutCycles, 256, maximum ACCESS cycles before the transfer is aborted; 0 disables the timeout.
- TimeoutRdata, 32'hDEAD_BEEF, read data returned on a timeout abort.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- reg_valid_i  in  1  request valid.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  AddrWidth  request address.
- reg_wdata_i  in  DataWidth  write data.
- reg_wstrb_i  in  DataWidth/8  write byte strobes.
- reg_ready_o  out  1  response valid and handshake complete.
- reg_rdata_o  out  DataWidth  read data.
- reg_error_o  out  1  transfer error (PSLVERR or timeout).
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  AddrWidth  APB address.
- pwdata_o  out  DataWidth  APB write data.
- pstrb_o  out  DataWidth/8  APB strobes.
- pprot_o  out  3  APB protection; constant 3'b000.
- pready_i  in  1  APB ready.
- prdata_i  in  DataWidth  APB read data.
- pslverr_i  in  1  APB slave error.

Behaviour:
- One clock domain. Reset is synchronous and active-high (clk_i / rst_i).
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs 0; captured address, data, strobe, rdata and error registers cleared; timeout counter cleared.
- IDLE:
  - psel=0, penable=0, reg_ready=0.
  - If reg_valid_i=1: latch write, addr, wdata and wstrb into internal registers, then go to SETUP.
  - For reads, the latched wdata and wstrb are forced to 0 (APB4 rule: pstrb is low on reads).
- SETUP (exactly 1 cycle):
  - psel=1, penable=0; paddr, pwrite, pwdata and pstrb are driven from the latched registers.
  - Go to ACCESS.
- ACCESS:
  - psel=1, penable=1; APB outputs stay stable.
  - If pready_i=1: capture rdata (prdata_i for reads, 0 for writes) and error=pslverr_i, then go to RESP.
  - Otherwise increment the counter.
  - If TimeoutCycles!=0 and the counter reaches TimeoutCycles-1 with pready_i still 0: capture rdata=TimeoutRdata (reads) or 0 (writes), error=1, then go to RESP.
  - Timeout boundary: pready_i=1 on the final counted cycle takes priority over the timeout (normal completion).
- RESP (exactly 1 cycle):
  - reg_ready_o=1; reg_rdata_o and reg_error_o are driven from the captured registers.
  - psel=0, penable=0.
  - Clear the counter and go to IDLE.
- reg_ready_o, reg_rdata_o and reg_error_o are registered outputs. reg_rdata_o and reg_error_o are valid only while reg_ready_o=1 and are driven 0 otherwise.
- Latency: reg_valid_i rising in cycle 0 with zero APB wait states gives psel at cycle 1, penable at cycle 2 and reg_ready at cycle 3. Each wait state adds one cycle.
- Throughput: at most one transfer per 4 cycles. A request held valid right after RESP is accepted in the following IDLE cycle.
- Request stability: the master holds the request until reg_ready. The bridge samples the request only in IDLE, so changes after acceptance are ignored.
- pready_i, prdata_i and pslverr_i are ignored outside ACCESS.
- Reset mid-transfer: at the next edge the FSM returns to IDLE with psel and penable low and no reg_ready pulse. The aborted transfer gets no response.
- Counter width: $clog2(TimeoutCycles+1), minimum 1 bit.
- paddr is passed through unmodified; no alignment or range checking is done.

Decomposition:
- APB request/response typedefs, RegDataWidth, and the Pad/FLL region constants live in chimera_pkg.
- The FSM state enum is local to the module.
- The bridge is a single module. The timeout counter is small enough to stay inline, so no sub-module is needed.

Test Plan:
- Write, zero wait states: addr 0x3000_2004, wdata 0xA5A5_0001, wstrb 0xF, pready=1 in the first ACCESS cycle -> psel at cycle 1, penable at cycle 2, pwdata 0xA5A5_0001, pstrb 0xF, reg_ready at cycle 3 with error=0.
- Read, 3 wait states: addr 0x3000_3010, pready after 3 ACCESS cycles with prdata 0x1234_5678 -> pstrb=0 and pwdata=0 throughout, reg_ready at cycle 6, rdata 0x1234_5678, error=0.
- Slave error: write with pready=1 and pslverr=1 -> reg_error=1, reg_rdata=0 on the reg_ready cycle.
- Timeout: TimeoutCycles=8, read, pready held 0 -> exactly 8 ACCESS cycles, then psel drops and reg_ready=1 with error=1 and rdata=0xDEAD_BEEF. A late pready afterwards is ignored.
- Back-to-back: second request presented immediately after the first reg_ready -> second SETUP occurs 2 cycles after the first RESP, with no overlap of psel between transfers.
- Reset mid-transfer: rst_i=1 during ACCESS -> next cycle psel=0, penable=0, reg_ready=0. After release, a fresh read completes normally with correct data.

Source files
------------

// File: rtl/chimera_reg_to_apb_pkg.sv
// Shared types and constants for the register-bus to APB4 bridge and the
// Pad/FLL configuration regions it serves.
package chimera_reg_to_apb_pkg;

  localparam int unsigned RegAddrWidth = 32;
  localparam int unsigned RegDataWidth = 32;
  localparam int unsigned RegStrbWidth = RegDataWidth / 8;

  localparam logic [RegAddrWidth-1:0] PadRegionStart = 32'h3000_2000;
  localparam logic [RegAddrWidth-1:0] PadRegionEnd   = 32'h3000_3000;
  localparam logic [RegAddrWidth-1:0] FllRegionStart = 32'h3000_3000;
  localparam logic [RegAddrWidth-1:0] FllRegionEnd   = 32'h3000_4000;

  typedef struct packed {
    logic [RegAddrWidth-1:0] paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [RegDataWidth-1:0] pwdata;
    logic [RegStrbWidth-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic                    pready;
    logic [RegDataWidth-1:0] prdata;
    logic                    pslverr;
  } apb_resp_t;

  // Width of a counter able to hold 0..cycles, never narrower than one bit.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chimera_reg_to_apb_if.sv
// Register-bus request/response interface and APB4 interface used by the bridge.
interface chimera_reg_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                   reg_valid_i;
  logic                   reg_write_i;
  logic [AddrWidth-1:0]   reg_addr_i;
  logic [DataWidth-1:0]   reg_wdata_i;
  logic [DataWidth/8-1:0] reg_wstrb_i;
  logic                   reg_ready_o;
  logic [DataWidth-1:0]   reg_rdata_o;
  logic                   reg_error_o;

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o
  );

  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_ready_o, reg_rdata_o, reg_error_o
  );
endinterface

interface chimera_apb_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                   psel_o;
  logic                   penable_o;
  logic                   pwrite_o;
  logic [AddrWidth-1:0]   paddr_o;
  logic [DataWidth-1:0]   pwdata_o;
  logic [DataWidth/8-1:0] pstrb_o;
  logic [2:0]             pprot_o;
  logic                   pready_i;
  logic [DataWidth-1:0]   prdata_i;
  logic                   pslverr_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o,
    output pready_i, prdata_i, pslverr_i
  );
endinterface

// File: rtl/chimera_reg_to_apb.sv
// Bridges one valid/ready register transaction into one APB4 SETUP/ACCESS
// transfer, with a PREADY timeout so a hung peripheral cannot stall the bus.
module chimera_reg_to_apb
  import chimera_reg_to_apb_pkg::*;
#(
  parameter int unsigned          AddrWidth     = RegAddrWidth,
  parameter int unsigned          DataWidth     = RegDataWidth,
  parameter int unsigned          TimeoutCycles = 256,
  parameter logic [DataWidth-1:0] TimeoutRdata  = 32'hDEAD_BEEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  chimera_reg_if.slave  reg_bus,
  chimera_apb_if.master apb
);

  localparam int unsigned CntWidth  = timeout_cnt_width(TimeoutCycles);
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   r_write;
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_wdata;
  logic [StrbWidth-1:0]   r_wstrb;
  logic [DataWidth-1:0]   r_rdata;
  logic                   r_error;
  logic                   r_ready;
  logic [CntWidth-1:0]    r_cnt;
  logic                   w_cnt_last;

  if (TimeoutCycles != 0) begin : g_timeout
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
    assign w_cnt_last = (r_cnt == CntLast);
  end else begin : g_no_timeout
    assign w_cnt_last = 1'b0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (reg_bus.reg_valid_i) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (apb.pready_i || w_cnt_last) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == RESP);
      case (r_state)
        IDLE: begin
          if (reg_bus.reg_valid_i) begin
            r_write <= reg_bus.reg_write_i;
            r_addr  <= reg_bus.reg_addr_i;
            r_wdata <= reg_bus.reg_write_i ? reg_bus.reg_wdata_i : '0;
            r_wstrb <= reg_bus.reg_write_i ? reg_bus.reg_wstrb_i : '0;
          end
        end
        ACCESS: begin
          // A ready on the last counted cycle wins over the timeout abort.
          if (apb.pready_i) begin
            r_rdata <= r_write ? '0 : apb.prdata_i;
            r_error <= apb.pslverr_i;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_rdata <= r_write ? '0 : TimeoutRdata;
            r_error <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          // Response fields read as zero whenever reg_ready_o is low.
          r_rdata <= '0;
          r_error <= 1'b0;
          r_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign apb.psel_o      = (r_state == SETUP) || (r_state == ACCESS);
  assign apb.penable_o   = (r_state == ACCESS);
  assign apb.pwrite_o    = r_write;
  assign apb.paddr_o     = r_addr;
  assign apb.pwdata_o    = r_wdata;
  assign apb.pstrb_o     = r_wstrb;
  assign apb.pprot_o     = 3'b000;

  assign reg_bus.reg_ready_o = r_ready;
  assign reg_bus.reg_rdata_o = r_rdata;
  assign reg_bus.reg_error_o = r_error;

endmodule
